// File: rtl/demux_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : demux_pkg
//  Description : Shared constants and types for the 1-to-2 16-bit stream
//                demultiplexer: default data width and FIFO depth, the
//                channel select encoding and the statistics counter width.
//  Revision    : 1.0 - initial release
// ============================================================================
package demux_pkg;

    // Default data width of the input word and both output channels.
    localparam int WIDTH_DEF = 16;

    // Default entries per output FIFO (power of two, minimum 2).
    localparam int DEPTH_DEF = 2;

    // Width of the per-channel accepted-push counters (optional statistics).
    localparam int STAT_W = 8;

    // Channel select encoding carried on in_control.
    typedef enum logic {
        CH_A = 1'b0,
        CH_B = 1'b1
    } channel_e;

endpackage : demux_pkg
`default_nettype wire

// File: rtl/demux1x2_16bits_stream_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_sync_16bits
//  Description : Single-clock synchronous FIFO used as the per-channel output
//                buffer of the stream demultiplexer. Push and pop may occur in
//                the same cycle; the head word is presented combinationally
//                from the storage array.
//  Revision    : 1.0 - initial release
//
//  Parameters  : WIDTH  data width
//                DEPTH  number of entries (power of two, minimum 2)
//
//  Ports       : clk          rising-edge clock
//                reset        synchronous active-high reset
//                i_push       write i_push_data (ignored when full)
//                i_push_data  word to write
//                i_pop        advance read pointer (ignored when empty)
//                o_full       count == DEPTH
//                o_empty      count == 0
//                o_count      number of stored words
//                o_head       oldest stored word
// ============================================================================
module fifo_sync_16bits
    import demux_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_push_data,
    input  logic                       i_pop,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic [WIDTH-1:0]           o_head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] mem_q   [DEPTH];
    logic [WIDTH-1:0] mem_d   [DEPTH];
    logic [PTR_W-1:0] wptr_q;
    logic [PTR_W-1:0] wptr_d;
    logic [PTR_W-1:0] rptr_q;
    logic [PTR_W-1:0] rptr_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    logic             w_full;
    logic             w_empty;
    logic             w_do_push;
    logic             w_do_pop;

    // ------------------------------------------------------------------------
    // Status and qualified handshakes
    // ------------------------------------------------------------------------
    assign w_full    = (count_q == FULL_CNT);
    assign w_empty   = (count_q == '0);

    // The FIFO protects itself: a push while full or a pop while empty is
    // dropped here, independent of what the caller gates upstream.
    assign w_do_push = i_push & ~w_full;
    assign w_do_pop  = i_pop  & ~w_empty;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        mem_d = mem_q;
        if (w_do_push) begin
            mem_d[wptr_q] = i_push_data;
        end
    end

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        // DEPTH is a power of two, so the pointers wrap by simple overflow.
        if (w_do_push) begin
            wptr_d = wptr_q + PTR_W'(1);
        end
        if (w_do_pop) begin
            rptr_d = rptr_q + PTR_W'(1);
        end
    end

    always_comb begin
        count_d = count_q;
        unique case ({w_do_push, w_do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    // Storage is cleared on reset so the head reads as zero right after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_count = count_q;
    assign o_head  = mem_q[rptr_q];

endmodule : fifo_sync_16bits
`default_nettype wire

// File: rtl/demux1x2_16bits_stream.sv
`default_nettype none
// ============================================================================
//  Module      : demux1x2_16bits_stream
//  Description : Registered 1-to-2 stream demultiplexer. One WIDTH-bit word
//                per cycle is accepted on a valid/ready input and routed to
//                channel A (in_control=0) or channel B (in_control=1). Each
//                channel owns a FIFO so a stalled consumer never disturbs the
//                other channel.
//  Revision    : 1.0 - initial release
//
//  Optional    : DEMUX_STATS_EN - adds per-channel accepted-push counters
//                (stat_a_cnt, stat_b_cnt) and a stall indicator (stat_stall).
//
//  Ports       : clk         rising-edge clock
//                reset       synchronous active-high reset
//                in_data     word to route
//                in_control  channel select, stable while in_valid=1
//                in_valid    in_data/in_control valid
//                in_ready    selected channel FIFO has space
//                a_data      head of FIFO A
//                a_valid     FIFO A non-empty
//                a_ready     consumer A takes head
//                b_data      head of FIFO B
//                b_valid     FIFO B non-empty
//                b_ready     consumer B takes head
//                stat_a_cnt  accepted pushes to A, wraps (DEMUX_STATS_EN)
//                stat_b_cnt  accepted pushes to B, wraps (DEMUX_STATS_EN)
//                stat_stall  in_valid=1 and in_ready=0 (DEMUX_STATS_EN)
// ============================================================================
module demux1x2_16bits_stream
    import demux_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_control,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [WIDTH-1:0]     a_data,
    output logic                 a_valid,
    input  logic                 a_ready,
    output logic [WIDTH-1:0]     b_data,
    output logic                 b_valid,
    input  logic                 b_ready
`ifdef DEMUX_STATS_EN
    ,
    output logic [STAT_W-1:0]    stat_a_cnt,
    output logic [STAT_W-1:0]    stat_b_cnt,
    output logic                 stat_stall
`endif
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    // ------------------------------------------------------------------------
    // Routing and flow control
    // ------------------------------------------------------------------------
    channel_e          w_sel;
    logic [CNT_W-1:0]  w_count_a;
    logic [CNT_W-1:0]  w_count_b;
    logic              w_full_a;
    logic              w_full_b;
    logic              w_empty_a;
    logic              w_empty_b;
    logic              w_space_a;
    logic              w_space_b;
    logic              w_accept;
    logic              w_push_a;
    logic              w_push_b;
    logic              w_pop_a;
    logic              w_pop_b;

    assign w_sel     = channel_e'(in_control);

    // Ready reflects only the registered occupancy of the selected FIFO; a
    // pop in the same cycle does not open space for a push into a full FIFO.
    assign w_space_a = (w_count_a != FULL_CNT);
    assign w_space_b = (w_count_b != FULL_CNT);
    assign in_ready  = (w_sel == CH_B) ? w_space_b : w_space_a;

    assign w_accept  = in_valid & in_ready;

    // Only the selected FIFO sees the push; the other one is untouched.
    assign w_push_a  = w_accept & (w_sel == CH_A) & ~w_full_a;
    assign w_push_b  = w_accept & (w_sel == CH_B) & ~w_full_b;

    assign a_valid   = ~w_empty_a;
    assign b_valid   = ~w_empty_b;
    assign w_pop_a   = a_valid & a_ready;
    assign w_pop_b   = b_valid & b_ready;

    // ------------------------------------------------------------------------
    // Per-channel output FIFOs
    // ------------------------------------------------------------------------
    fifo_sync_16bits #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo_a (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_push_a),
        .i_push_data (in_data),
        .i_pop       (w_pop_a),
        .o_full      (w_full_a),
        .o_empty     (w_empty_a),
        .o_count     (w_count_a),
        .o_head      (a_data)
    );

    fifo_sync_16bits #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo_b (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_push_b),
        .i_push_data (in_data),
        .i_pop       (w_pop_b),
        .o_full      (w_full_b),
        .o_empty     (w_empty_b),
        .o_count     (w_count_b),
        .o_head      (b_data)
    );

`ifdef DEMUX_STATS_EN
    // ------------------------------------------------------------------------
    // Statistics: accepted pushes per channel (wrapping) and stall flag
    // ------------------------------------------------------------------------
    logic [STAT_W-1:0] stat_a_cnt_q;
    logic [STAT_W-1:0] stat_a_cnt_d;
    logic [STAT_W-1:0] stat_b_cnt_q;
    logic [STAT_W-1:0] stat_b_cnt_d;

    always_comb begin
        stat_a_cnt_d = stat_a_cnt_q;
        stat_b_cnt_d = stat_b_cnt_q;
        if (w_push_a) begin
            stat_a_cnt_d = stat_a_cnt_q + STAT_W'(1);
        end
        if (w_push_b) begin
            stat_b_cnt_d = stat_b_cnt_q + STAT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_a_cnt_q <= '0;
            stat_b_cnt_q <= '0;
        end else begin
            stat_a_cnt_q <= stat_a_cnt_d;
            stat_b_cnt_q <= stat_b_cnt_d;
        end
    end

    assign stat_a_cnt = stat_a_cnt_q;
    assign stat_b_cnt = stat_b_cnt_q;
    assign stat_stall = in_valid & ~in_ready;
`endif

endmodule : demux1x2_16bits_stream
`default_nettype wire

// File: tb/tb_demux1x2_16bits_stream.sv
`default_nettype none
// ============================================================================
//  Module      : tb_demux1x2_16bits_stream
//  Description : Self-checking bench for demux1x2_16bits_stream. Accepted
//                words are pushed to a per-channel expected queue; the head
//                of each queue is compared with the DUT output while the
//                channel is valid and popped on each consumer handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_demux1x2_16bits_stream;

    localparam int WIDTH = 16;
    localparam int DEPTH = 2;

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] in_data;
    logic             in_control;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a_data;
    logic             a_valid;
    logic             a_ready;
    logic [WIDTH-1:0] b_data;
    logic             b_valid;
    logic             b_ready;
`ifdef DEMUX_STATS_EN
    logic [7:0]       stat_a_cnt;
    logic [7:0]       stat_b_cnt;
    logic             stat_stall;
`endif

    demux1x2_16bits_stream #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_control (in_control),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a_data     (a_data),
        .a_valid    (a_valid),
        .a_ready    (a_ready),
        .b_data     (b_data),
        .b_valid    (b_valid),
        .b_ready    (b_ready)
`ifdef DEMUX_STATS_EN
        ,
        .stat_a_cnt (stat_a_cnt),
        .stat_b_cnt (stat_b_cnt),
        .stat_stall (stat_stall)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Scoreboard state
    logic [WIDTH-1:0] sb_a[$];
    logic [WIDTH-1:0] sb_b[$];
    logic [7:0]       mdl_cnt_a;
    logic [7:0]       mdl_cnt_b;
    int               n_checks;
    int               n_fail;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Hold reset for a number of edges; the model is emptied at the last edge.
    task automatic do_reset(input int cycles);
        reset    = 1'b1;
        in_valid = 1'b0;
        a_ready  = 1'b0;
        b_ready  = 1'b0;
        repeat (cycles) @(posedge clk);
        sb_a.delete();
        sb_b.delete();
        mdl_cnt_a = 8'd0;
        mdl_cnt_b = 8'd0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // One clock cycle, entered and left at a falling edge. Checks outputs
    // against the model before the rising edge, then applies the expected
    // push/pop to the model at the edge.
    task automatic step(input logic v, input logic c, input logic [WIDTH-1:0] d,
                        input logic ar, input logic br, output logic acc);
        logic exp_rdy;
        logic pop_a;
        logic pop_b;
        in_valid   = v;
        in_control = c;
        in_data    = d;
        a_ready    = ar;
        b_ready    = br;
        #1;
        exp_rdy = c ? (sb_b.size() != DEPTH) : (sb_a.size() != DEPTH);
        check_eq("in_ready", in_ready, exp_rdy);
        check_eq("a_valid", a_valid, sb_a.size() != 0);
        check_eq("b_valid", b_valid, sb_b.size() != 0);
        if (sb_a.size() != 0) check_eq("a_data", a_data, sb_a[0]);
        if (sb_b.size() != 0) check_eq("b_data", b_data, sb_b[0]);
`ifdef DEMUX_STATS_EN
        check_eq("stat_a_cnt", stat_a_cnt, mdl_cnt_a);
        check_eq("stat_b_cnt", stat_b_cnt, mdl_cnt_b);
        check_eq("stat_stall", stat_stall, v & ~exp_rdy);
`endif
        pop_a = (sb_a.size() != 0) && ar;
        pop_b = (sb_b.size() != 0) && br;
        acc   = v && exp_rdy;
        @(posedge clk);
        if (pop_a) void'(sb_a.pop_front());
        if (pop_b) void'(sb_b.pop_front());
        if (acc) begin
            if (c) begin
                sb_b.push_back(d);
                mdl_cnt_b = mdl_cnt_b + 8'd1;
            end else begin
                sb_a.push_back(d);
                mdl_cnt_a = mdl_cnt_a + 8'd1;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        logic             acc;
        logic             pv;
        logic             pc;
        logic [WIDTH-1:0] pd;
        logic             hold;

        n_checks   = 0;
        n_fail     = 0;
        mdl_cnt_a  = 8'd0;
        mdl_cnt_b  = 8'd0;
        in_data    = '0;
        in_control = 1'b0;

        // Reset state
        do_reset(2);
        #1;
        check_eq("rst_a_data", a_data, 16'h0000);
        check_eq("rst_b_data", b_data, 16'h0000);
        check_eq("rst_in_ready", in_ready, 1'b1);

        // Single word to A, then pop
        step(1'b1, 1'b0, 16'h1234, 1'b0, 1'b0, acc);
        step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, acc);
        step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, acc);

        // Alternating channels, both consumers ready
        step(1'b1, 1'b0, 16'hA001, 1'b1, 1'b1, acc);
        step(1'b1, 1'b1, 16'hB001, 1'b1, 1'b1, acc);
        step(1'b1, 1'b0, 16'hA002, 1'b1, 1'b1, acc);
        repeat (3) step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, acc);

        // Fill A with consumer stalled; third push blocked; B still accepts
        step(1'b1, 1'b0, 16'hC001, 1'b0, 1'b0, acc);
        step(1'b1, 1'b0, 16'hC002, 1'b0, 1'b0, acc);
        step(1'b1, 1'b0, 16'hC003, 1'b0, 1'b0, acc);
        check_eq("fullA_blocked", acc, 1'b0);
        step(1'b1, 1'b1, 16'hD001, 1'b0, 1'b0, acc);
        check_eq("B_accept_while_A_full", acc, 1'b1);
        // Pop and push to full A in the same cycle: push must wait
        step(1'b1, 1'b0, 16'hC003, 1'b1, 1'b0, acc);
        check_eq("full_pop_push_blocked", acc, 1'b0);
        step(1'b1, 1'b0, 16'hC003, 1'b1, 1'b0, acc);
        check_eq("retry_accepted", acc, 1'b1);
        repeat (4) step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, acc);

        // Fill B, reset mid-operation, then a lone word
        step(1'b1, 1'b1, 16'hE001, 1'b0, 1'b0, acc);
        step(1'b1, 1'b1, 16'hE002, 1'b0, 1'b0, acc);
        do_reset(1);
        #1;
        check_eq("midrst_b_valid", b_valid, 1'b0);
        check_eq("midrst_b_data", b_data, 16'h0000);
        @(negedge clk);
        step(1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0, acc);
        step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, acc);
        step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, acc);

        // Random traffic; a refused word is held stable until accepted
        hold = 1'b0;
        pv = 1'b0;
        pc = 1'b0;
        pd = '0;
        for (int i = 0; i < 400; i++) begin
            if (!hold) begin
                pv = 1'($urandom_range(0, 1));
                pc = 1'($urandom_range(0, 1));
                pd = 16'($urandom);
            end
            step(pv, pc, pd, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), acc);
            hold = pv && !acc;
        end
        repeat (4) step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, acc);

`ifdef DEMUX_STATS_EN
        // 257 accepted pushes to A wrap the counter to 1
        do_reset(1);
        for (int i = 0; i < 257; i++) begin
            step(1'b1, 1'b0, 16'(i), 1'b1, 1'b0, acc);
        end
        #1;
        check_eq("stat_a_wrap", stat_a_cnt, 8'd1);
        check_eq("stat_b_zero", stat_b_cnt, 8'd0);
        @(negedge clk);
        // Blocked cycles raise stat_stall (checked inside step)
        step(1'b1, 1'b0, 16'h5A01, 1'b0, 1'b0, acc);
        step(1'b1, 1'b0, 16'h5A02, 1'b0, 1'b0, acc);
        step(1'b1, 1'b0, 16'h5A03, 1'b0, 1'b0, acc);
        repeat (4) step(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, acc);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_demux1x2_16bits_stream
`default_nettype wire
